fp32_sqrt_arb: RTL and testbench

FP32_SQRT_ARB -- requirements
Module: fp32_sqrt_arb

---
 rtl/fp32_sqrt_arb.sv | 157 +++++++++++++++
 tb/tb_fp32_sqrt_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_sqrt_arb.sv
// Round-robin front end sharing one fp32_sqrt pipeline among NUM_REQ requesters.
// Optional counters stat_issued/stat_stall are enabled by FP32_SQRT_ARB_STATS_EN.
module fp32_sqrt_arb #(
    parameter int NUM_REQ    = 4,
    parameter int SQRT_LAT   = 27,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*32-1:0]         req_a,
    output logic [31:0]                   sqrt_a,
    input  logic [31:0]                   sqrt_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [$clog2(FIFO_DEPTH):0]   inflight
`ifdef FP32_SQRT_ARB_STATS_EN
    ,
    output logic [31:0]                   stat_issued,
    output logic [31:0]                   stat_stall
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      ops [NUM_REQ];
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant;
    logic             any_req;
    logic             xfer;
    logic [CNT_W-1:0] credits;

    logic [SQRT_LAT-1:0] tag_v;
    logic [ID_W-1:0]     tag_id [SQRT_LAT];
    logic                push;
    logic                pop;

    logic [31:0]      mem_data [FIFO_DEPTH];
    logic [ID_W-1:0]  mem_id   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
        assign ops[g] = req_a[32*g +: 32];
    end

    // Scan downward so the first valid index at or after rr_ptr wins.
    always_comb begin
        int idx;
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx[ID_W-1:0]]) begin
                grant   = idx[ID_W-1:0];
                any_req = 1'b1;
            end
        end
    end

    assign xfer = rst_n && any_req && (credits != '0);

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            sqrt_a   <= 32'h0;
            credits  <= CNT_W'(FIFO_DEPTH);
            inflight <= '0;
        end else begin
            if (xfer) begin
                rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
            sqrt_a <= xfer ? ops[grant] : 32'h0;
            case ({xfer, pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
            case ({xfer, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Only valid bits need reset; stale ids behind a cleared valid are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tag_v <= '0;
        else        tag_v <= {tag_v[SQRT_LAT-2:0], xfer};
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= grant;
        for (int i = 1; i < SQRT_LAT; i++) tag_id[i] <= tag_id[i-1];
    end

    assign push = tag_v[SQRT_LAT-1];

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : 32'h0;
    assign rsp_id    = rsp_valid ? mem_id[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= sqrt_result;
            mem_id[wr_ptr]   <= tag_id[SQRT_LAT-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FP32_SQRT_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= 32'h0;
            stat_stall  <= 32'h0;
        end else begin
            if (xfer && stat_issued != 32'hFFFF_FFFF) begin
                stat_issued <= stat_issued + 32'h1;
            end
            if ((|req_valid) && credits == '0 && stat_stall != 32'hFFFF_FFFF) begin
                stat_stall <= stat_stall + 32'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp32_sqrt_arb.sv
// Directed bench for fp32_sqrt_arb with a table-driven stand-in for fp32_sqrt.
module tb_fp32_sqrt_arb;

    localparam int NR    = 4;
    localparam int LAT   = 27;
    localparam int DEPTH = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*32-1:0] req_a;
    logic [31:0]     sqrt_a;
    logic [31:0]     sqrt_result;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_data;
    logic [1:0]      rsp_id;
    logic [5:0]      inflight;
`ifdef FP32_SQRT_ARB_STATS_EN
    logic [31:0]     stat_issued;
    logic [31:0]     stat_stall;
`endif

    always #5 clk = ~clk;

    fp32_sqrt_arb #(
        .NUM_REQ(NR), .SQRT_LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a),
        .sqrt_a(sqrt_a), .sqrt_result(sqrt_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .inflight(inflight)
`ifdef FP32_SQRT_ARB_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    function automatic logic [31:0] sqrt_ref(input logic [31:0] a);
        case (a)
            32'h40800000: sqrt_ref = 32'h40000000;
            32'h41100000: sqrt_ref = 32'h40400000;
            32'hBF800000: sqrt_ref = 32'h7FC00001;
            32'h00000000: sqrt_ref = 32'h00000000;
            default:      sqrt_ref = ~a;
        endcase
    endfunction

    // Result is sampled by the arbiter LAT edges after the transfer edge.
    logic [31:0] pipe [LAT-1];
    always @(posedge clk) begin
        pipe[0] <= sqrt_ref(sqrt_a);
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign sqrt_result = pipe[LAT-2];

    logic ovf_seen = 1'b0;
    always @(posedge clk) begin
        if (rst_n && dut.push && dut.count == 6'(DEPTH) && !dut.pop) begin
            ovf_seen <= 1'b1;
            $display("FAIL fifo_overflow push while full at %0t", $time);
        end
    end

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } rsp_t;
    rsp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int n;
        int got;
        int exp_ptr;
        int issued;
        bit bad;
        logic [3:0] exp_rdy;

        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();

        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);

        // single op from requester 2
        rst_n          = 1'b1;
        req_valid      = 4'b0100;
        req_a[64 +: 32] = 32'h40800000;
        #1;
        chk("single_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        n = 1;
        chk("single_inflight", 32'(inflight), 32'h1);
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk("single_latency", n, LAT + 1);
        chk("single_data", rsp_data, 32'h40000000);
        chk("single_id", 32'(rsp_id), 32'h2);
        tick();
        chk("single_popped", 32'(rsp_valid), 32'h0);

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // round robin, all requesters valid with 9.0
        req_valid = 4'hF;
        for (int i = 0; i < NR; i++) req_a[32*i +: 32] = 32'h41100000;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            tick();
        end
        req_valid = '0;
        #1;
        got = 0;
        for (int c = 0; c < 100 && got < 8; c++) begin
            if (rsp_valid) begin
                chk("rr_data", rsp_data, 32'h40400000);
                chk("rr_id", 32'(rsp_id), 32'(got % 4));
                got++;
            end
            tick();
        end
        chk("rr_count", got, 8);

        // -1.0 from requester 1
        req_valid       = 4'b0010;
        req_a[32 +: 32] = 32'hBF800000;
        #1;
        chk("neg_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        n = 1;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk("neg_data", rsp_data, 32'h7FC00001);
        chk("neg_id", 32'(rsp_id), 32'h1);
        tick();
        exp_ptr = 2;

        // backpressure fills exactly DEPTH credits
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < NR; i++) req_a[32*i +: 32] = 32'h30000000 + 32'(i);
        #1;
        issued = 0;
        for (int c = 0; c < 72; c++) begin
            exp_rdy = (issued < DEPTH) ? 4'(1 << exp_ptr) : 4'h0;
            chk("bp_grant", 32'(req_ready), 32'(exp_rdy));
            if (exp_rdy != 4'h0) begin
                sb.push_back('{2'(exp_ptr), ~(32'h30000000 + 32'(exp_ptr))});
                issued++;
                exp_ptr = (exp_ptr + 1) % NR;
            end
            tick();
        end
        chk("bp_inflight", 32'(inflight), 32'h0);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);

        // one pop frees a credit, then transfer and pop in the same cycle
        rsp_ready = 1'b1;
        #1;
        chk("zc_ready", 32'(req_ready), 32'h0);
        chk("zc_head_data", rsp_data, sb[0].data);
        void'(sb.pop_front());
        tick();
        chk("both_credits_pre", 32'(dut.credits), 32'h1);
        chk("both_grant", 32'(req_ready), 32'(1 << exp_ptr));
        chk("both_head_id", 32'(rsp_id), 32'(sb[0].id));
        void'(sb.pop_front());
        sb.push_back('{2'(exp_ptr), ~(32'h30000000 + 32'(exp_ptr))});
        exp_ptr = (exp_ptr + 1) % NR;
        tick();
        chk("both_credits_post", 32'(dut.credits), 32'h1);
        rsp_ready = 1'b0;
        #1;
        chk("last_grant", 32'(req_ready), 32'(1 << exp_ptr));
        sb.push_back('{2'(exp_ptr), ~(32'h30000000 + 32'(exp_ptr))});
        exp_ptr = (exp_ptr + 1) % NR;
        tick();
        chk("stall_ready", 32'(req_ready), 32'h0);
        req_valid = '0;

        // drain in issue order
        rsp_ready = 1'b1;
        #1;
        for (int c = 0; c < 200 && sb.size() > 0; c++) begin
            if (rsp_valid) begin
                chk("drain_data", rsp_data, sb[0].data);
                chk("drain_id", 32'(rsp_id), 32'(sb[0].id));
                void'(sb.pop_front());
            end
            tick();
        end
        chk("drain_left", sb.size(), 0);
        chk("drain_empty", 32'(rsp_valid), 32'h0);

        // issue resumes
        req_valid = 4'b0001;
        #1;
        chk("resume_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("resume_inflight", 32'(inflight), 32'h1);

        // reset with ops in flight
        req_valid = 4'hF;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_inflight", 32'(inflight), 32'h0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_data", rsp_data, 32'h0);
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 2 * LAT; c++) begin
            tick();
            if (rsp_valid !== 1'b0) bad = 1'b1;
        end
        chk("post_rst_quiet", 32'(bad), 32'h0);
        chk("post_rst_inflight", 32'(inflight), 32'h0);
        chk("no_overflow", 32'(ovf_seen), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
